timer_cmd_sequencer: RTL and testbench

APB master that sequences the 8-bit timer's register file (TDR, TCR, TSR, TCNT) from a compact command interface. It turns one command (start, pause, resume, reload, clear flags, read count/status) into the required ordered APB transfers. It keeps a shadow copy of TCR so that pause and resume never alter direction or clock select. It sits between a system controller/CPU-lite and the timer's APB slave port, which it drives as the sole master.

---
 rtl/timer_pkg.sv | 36 +++
 rtl/timer_cmd_sequencer_apb_master_xfer.sv | 67 ++++++
 rtl/timer_cmd_sequencer.sv | 172 +++++++++++++++++
 tb/tb_timer_cmd_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: register map, TCR/TSR bit positions, command opcodes and FSM states for the 8-bit timer
package timer_pkg;

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;

    localparam int TCR_UPDW = 4;
    localparam int TCR_EN   = 5;
    localparam int TCR_LOAD = 7;
    localparam int TSR_OVF  = 0;
    localparam int TSR_UDF  = 1;

    typedef enum logic [2:0] {
        OP_START     = 3'd0,
        OP_PAUSE     = 3'd1,
        OP_RESUME    = 3'd2,
        OP_RELOAD    = 3'd3,
        OP_CLR_FLAGS = 3'd4,
        OP_READ_CNT  = 3'd5,
        OP_READ_STS  = 3'd6,
        OP_NOP       = 3'd7
    } cmd_op_t;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    typedef enum logic [1:0] {Q_IDLE, Q_RUN, Q_DONE} seq_t;

    // Bit order matches Load bit7, En bit5, Up_Dw bit4, Cks[1:0].
    function automatic logic [7:0] tcr_word(input logic load, input logic en, input logic updw,
                                            input logic [1:0] cks);
        return {load, 1'b0, en, updw, 2'b00, cks};
    endfunction

endpackage

// File: rtl/timer_cmd_sequencer_apb_master_xfer.sv
// apb_master_xfer: one APB transfer (SETUP then ACCESS) with a PREADY timeout.
// A req on the completing edge chains the next transfer straight into SETUP.
module apb_master_xfer
    import timer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  write,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          tmo, take;

    assign tmo     = state == S_ACCESS && !PREADY && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign done    = state == S_ACCESS && (PREADY || tmo);
    assign err     = state == S_ACCESS && (PREADY ? PSLVERR : tmo);
    assign take    = req && (state == S_IDLE || done);
    assign rdata   = PRDATA;
    assign PSEL    = state != S_IDLE;
    assign PENABLE = state == S_ACCESS;

    always_comb begin
        state_nxt = state == S_SETUP ? S_ACCESS :
                    take             ? S_SETUP  :
                    (state == S_ACCESS && !done) ? S_ACCESS : S_IDLE;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state  <= S_IDLE;
            cnt    <= '0;
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == S_ACCESS && !PREADY) ? cnt + CW'(1) : '0;
            if (take) begin
                PWRITE <= write;
                PADDR  <= addr;
                PWDATA <= wdata;
            end
        end
    end

endmodule

// File: rtl/timer_cmd_sequencer.sv
// timer_cmd_sequencer: turns one timer command into its ordered list of APB transfers,
// keeping a shadow of TCR so pause/resume preserve direction and clock select.
module timer_cmd_sequencer
    import timer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_down,
    input  logic [1:0]            cmd_cks,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] tcr_shadow,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef struct packed {
        logic                  wr;
        logic                  last;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } step_t;

    localparam logic [DATA_WIDTH-1:0] EN_M   = DATA_WIDTH'(1) << TCR_EN;
    localparam logic [DATA_WIDTH-1:0] LOAD_M = DATA_WIDTH'(1) << TCR_LOAD;

    function automatic step_t step_of(input cmd_op_t op, input logic [1:0] i,
                                      input logic [DATA_WIDTH-1:0] d, input logic dn,
                                      input logic [1:0] ck, input logic [DATA_WIDTH-1:0] sh);
        step_t s;
        s.wr    = 1'b1;
        s.last  = 1'b1;
        s.addr  = ADDR_WIDTH'(ADDR_TCR);
        s.wdata = sh;
        case (op)
            OP_START: begin
                s.last  = i != 2'd0;
                s.addr  = ADDR_WIDTH'(i == 2'd0 ? ADDR_TDR : ADDR_TCR);
                s.wdata = i == 2'd0 ? d : DATA_WIDTH'(tcr_word(1'b0, 1'b1, dn, ck));
            end
            OP_PAUSE:  s.wdata = sh & ~EN_M;
            OP_RESUME: s.wdata = sh | EN_M;
            // Load pulses 0->1->0 so the timer sees a rising edge on TCR.Load.
            OP_RELOAD: begin
                s.last  = i == 2'd2;
                s.addr  = ADDR_WIDTH'(i == 2'd0 ? ADDR_TDR : ADDR_TCR);
                s.wdata = i == 2'd0 ? d : i == 2'd1 ? (sh | LOAD_M) : (sh & ~LOAD_M);
            end
            OP_CLR_FLAGS: begin
                s.addr  = ADDR_WIDTH'(ADDR_TSR);
                s.wdata = d;
            end
            OP_READ_CNT: begin
                s.wr    = 1'b0;
                s.addr  = ADDR_WIDTH'(ADDR_TCNT);
                s.wdata = '0;
            end
            OP_READ_STS: begin
                s.wr    = 1'b0;
                s.addr  = ADDR_WIDTH'(ADDR_TSR);
                s.wdata = '0;
            end
            default: ;
        endcase
        return s;
    endfunction

    seq_t                  q, q_nxt;
    cmd_op_t               op_r;
    logic [DATA_WIDTH-1:0] data_r, rdat_r, rdata;
    logic                  down_r, last_r, err_r;
    logic [1:0]            cks_r, idx_r, idx_n;
    logic                  accept, start, done, err;
    step_t                 stp;

    assign cmd_ready = q == Q_IDLE;
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = q == Q_DONE;
    assign rsp_data  = rsp_valid ? rdat_r : '0;
    assign rsp_err   = rsp_valid && err_r;

    // Step 0 is built from the live command inputs so SETUP starts right after acceptance.
    assign idx_n = accept ? 2'd0 : idx_r + 2'd1;
    assign stp   = step_of(accept ? cmd_op_t'(cmd_op) : op_r, idx_n,
                           accept ? cmd_data : data_r, accept ? cmd_down : down_r,
                           accept ? cmd_cks : cks_r, tcr_shadow);
    assign start = accept ? cmd_op != OP_NOP : (q == Q_RUN && done && !err && !last_r);

    always_comb begin
        q_nxt = q == Q_DONE ? Q_IDLE :
                q == Q_IDLE ? (accept ? (start ? Q_RUN : Q_DONE) : Q_IDLE) :
                (done && (err || last_r)) ? Q_DONE : Q_RUN;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            q          <= Q_IDLE;
            op_r       <= OP_NOP;
            data_r     <= '0;
            down_r     <= 1'b0;
            cks_r      <= 2'b00;
            idx_r      <= 2'd0;
            last_r     <= 1'b0;
            err_r      <= 1'b0;
            rdat_r     <= '0;
            tcr_shadow <= '0;
        end else begin
            q <= q_nxt;
            if (accept) begin
                op_r   <= cmd_op_t'(cmd_op);
                data_r <= cmd_data;
                down_r <= cmd_down;
                cks_r  <= cmd_cks;
                err_r  <= 1'b0;
                rdat_r <= '0;
            end
            if (start) begin
                idx_r  <= idx_n;
                last_r <= stp.last;
            end
            if (q == Q_RUN && done) begin
                err_r <= err;
                if (!PWRITE && PREADY)
                    rdat_r <= rdata;
                if (!err && PWRITE && PADDR == ADDR_WIDTH'(ADDR_TCR))
                    tcr_shadow <= PWDATA;
            end
        end
    end

    apb_master_xfer #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_xfer (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .req    (start),
        .addr   (stp.addr),
        .wdata  (stp.wdata),
        .write  (stp.wr),
        .done   (done),
        .err    (err),
        .rdata  (rdata),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR)
    );

endmodule

// File: tb/tb_timer_cmd_sequencer.sv
// tb_timer_cmd_sequencer: directed and random commands against a reactive APB slave and a
// transfer-list reference model of the command rules.
module tb_timer_cmd_sequencer;

    localparam int TO = 16;

    logic       PCLK = 1'b0, PRESET = 1'b1;
    logic       cmd_valid = 1'b0, cmd_down = 1'b0;
    logic [2:0] cmd_op = 3'd7;
    logic [7:0] cmd_data = 8'h00, PRDATA = 8'h00;
    logic [1:0] cmd_cks = 2'b00;
    logic       PREADY = 1'b0, PSLVERR = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_err, busy, PSEL, PENABLE, PWRITE;
    logic [7:0] rsp_data, tcr_shadow, PADDR, PWDATA;

    timer_cmd_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_down(cmd_down), .cmd_cks(cmd_cks),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .tcr_shadow(tcr_shadow), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } xfer_t;

    xfer_t      obs[$], expq[$];
    int         checks = 0, errors = 0;
    int         waits = 0, err_at = -1, step_no = 0, acc = 0, total_acc = 0;
    bit         stuck = 1'b0, prev_setup = 1'b0;
    logic [7:0] rdv = 8'h00, m_shadow = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave: answers after `waits` low cycles, PSLVERR on step err_at, never if stuck.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            total_acc++;
            if (acc == 0) begin
                check("setup_before_access", 32'(prev_setup), 32'd1);
                obs.push_back('{PWRITE, PADDR, PWRITE ? PWDATA : 8'h00});
            end else
                check("access_stable", 32'({PWRITE, PADDR, PWRITE ? PWDATA : 8'h00}), 32'(obs[$]));
            if (!stuck && acc >= waits) begin
                PREADY  = 1'b1;
                PSLVERR = step_no == err_at;
                PRDATA  = rdv;
                acc     = 0;
                step_no++;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'($urandom_range(0, 1));
                PRDATA  = 8'($urandom);
                acc++;
            end
        end else begin
            PREADY  = 1'($urandom_range(0, 1));
            PSLVERR = 1'b0;
            PRDATA  = 8'($urandom);
            acc     = 0;
        end
        prev_setup = PSEL && !PENABLE;
    end

    // Expected transfers, latency to rsp_valid, error and read data for one command.
    task automatic model(input logic [2:0] op, input logic [7:0] d, input logic dn,
                         input logic [1:0] ck, output int lat, output bit e, output logic [7:0] rd);
        int n;
        logic [7:0] sh, a, v;
        bit w;
        n   = op == 3'd0 ? 2 : op == 3'd3 ? 3 : op == 3'd7 ? 0 : 1;
        lat = 1;
        e   = 1'b0;
        rd  = 8'h00;
        sh  = m_shadow;
        expq.delete();
        for (int i = 0; i < n; i++) begin
            w = 1'b1;
            a = 8'h01;
            v = 8'h00;
            case (op)
                3'd0: begin a = i == 0 ? 8'h00 : 8'h01; v = i == 0 ? d : (8'h20 | (dn ? 8'h10 : 8'h00) | {6'd0, ck}); end
                3'd1: v = sh & ~8'h20;
                3'd2: v = sh | 8'h20;
                3'd3: begin a = i == 0 ? 8'h00 : 8'h01; v = i == 0 ? d : i == 1 ? (sh | 8'h80) : (sh & ~8'h80); end
                3'd4: begin a = 8'h02; v = d; end
                3'd5: begin w = 1'b0; a = 8'h03; end
                3'd6: begin w = 1'b0; a = 8'h02; end
                default: ;
            endcase
            expq.push_back('{w, a, v});
            if (stuck) begin lat += 1 + TO; e = 1'b1; break; end
            lat += 2 + waits;
            if (i == err_at) begin e = 1'b1; break; end
            if (w && a == 8'h01) sh = v;
            if (!w) rd = rdv;
        end
        m_shadow = sh;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, input logic dn,
                           input logic [1:0] ck, input int w, input int ea, input bit st,
                           input logic [7:0] rv);
        int lat, k;
        bit e;
        logic [7:0] rd;
        waits = w; err_at = ea; stuck = st; rdv = rv; step_no = 0; total_acc = 0;
        obs.delete();
        model(op, d, dn, ck, lat, e, rd);
        @(negedge PCLK);
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_down = dn; cmd_cks = ck;
        k = 0;
        do begin
            @(negedge PCLK);
            k++;
            if (k == 1) begin
                cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = 8'($urandom);
                cmd_down = 1'($urandom); cmd_cks = 2'($urandom);
            end
        end while (!rsp_valid && k < 300);
        check("latency", 32'(k), 32'(lat));
        check("rsp_err", 32'(rsp_err), 32'(e));
        if (!e) check("rsp_data", 32'(rsp_data), 32'(rd));
        check("psel_in_done", 32'(PSEL), 32'd0);
        check("shadow", 32'(tcr_shadow), 32'(m_shadow));
        check("xfer_count", 32'(obs.size()), 32'(expq.size()));
        foreach (expq[i]) if (i < obs.size()) check("xfer", 32'(obs[i]), 32'(expq[i]));
        if (st) check("timeout_cycles", 32'(total_acc), 32'(TO));
        @(negedge PCLK);
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge PCLK);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bus", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'd0);
        check("rst_shadow", 32'(tcr_shadow), 32'd0);
        PRESET = 1'b0;

        run_cmd(3'd0, 8'h10, 1'b0, 2'b00, 0, -1, 1'b0, 8'h00);
        run_cmd(3'd0, 8'h55, 1'b1, 2'b01, 1, -1, 1'b0, 8'h00);
        run_cmd(3'd1, 8'h00, 1'b0, 2'b00, 0, -1, 1'b0, 8'h00);
        run_cmd(3'd2, 8'h00, 1'b0, 2'b00, 2, -1, 1'b0, 8'h00);
        run_cmd(3'd0, 8'h00, 1'b0, 2'b00, 0, -1, 1'b0, 8'h00);
        run_cmd(3'd3, 8'hF0, 1'b0, 2'b00, 0, -1, 1'b0, 8'h00);
        run_cmd(3'd6, 8'h00, 1'b0, 2'b00, 3, -1, 1'b0, 8'h01);
        run_cmd(3'd0, 8'h77, 1'b1, 2'b11, 0, 0, 1'b0, 8'h00);
        run_cmd(3'd1, 8'h00, 1'b0, 2'b00, 0, -1, 1'b1, 8'h00);
        run_cmd(3'd4, 8'h03, 1'b0, 2'b00, 1, -1, 1'b0, 8'h00);
        run_cmd(3'd5, 8'h00, 1'b0, 2'b00, 0, -1, 1'b0, 8'hA5);
        run_cmd(3'd7, 8'h00, 1'b0, 2'b00, 0, -1, 1'b0, 8'h00);

        for (int n = 0; n < 60; n++)
            run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 2'($urandom),
                    $urandom_range(0, 2), ($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) : -1,
                    $urandom_range(0, 19) == 0, 8'($urandom));

        // Reset during ACCESS of the second RELOAD step.
        run_cmd(3'd0, 8'h20, 1'b1, 2'b01, 0, -1, 1'b0, 8'h00);
        waits = 3; err_at = -1; stuck = 1'b0; step_no = 0;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_data = 8'hF0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        seen = 0;
        while (!(step_no == 1 && PSEL && PENABLE) && seen < 50) begin
            @(negedge PCLK);
            seen++;
        end
        check("reach_step1_access", 32'(seen < 50), 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("mid_rst_psel", 32'({PSEL, PENABLE}), 32'd0);
        check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_shadow", 32'(tcr_shadow), 32'd0);
        PRESET = 1'b0;
        m_shadow = 8'h00;
        seen = 0;
        repeat (6) begin
            @(negedge PCLK);
            seen += int'(rsp_valid | PSEL);
        end
        check("mid_rst_quiet", 32'(seen), 32'd0);
        run_cmd(3'd2, 8'h00, 1'b0, 2'b00, 0, -1, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
